// File: rtl/chacha_fmt_pkg.sv
// chacha_fmt_pkg: shared types and constants for the AEAD formatter.
// Holds the FSM state enum, block geometry and keep helpers.
package chacha_fmt_pkg;

  localparam int BLK_BYTES  = 16;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AAD,
    ST_PLD,
    ST_LEN
  } state_t;

  // Number of set bits in a word's byte enables.
  function automatic logic [2:0] keep_cnt(
    input logic [3:0] keep
  );
    return 3'(keep[0]) + 3'(keep[1])
         + 3'(keep[2]) + 3'(keep[3]);
  endfunction

  // Block keep with the low n bits set (n = 0..16).
  function automatic logic [15:0] cnt_mask(
    input logic [4:0] n
  );
    return 16'(~(32'hFFFF_FFFF << n));
  endfunction

endpackage

// File: rtl/chacha_fmt_pack.sv
// chacha_fmt_pack: packs 32-bit words into 128-bit blocks and holds
// one registered output block tagged with its segment (0=AAD,1=PLD).
// Ports: clk/rst, clear (abort), wr/data/nbytes/last/seg (accepted
// word), aad_ready/pld_ready, ready/empty status, out_* block register.
module chacha_fmt_pack
  import chacha_fmt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr,
  input  logic [31:0]  data,
  input  logic [2:0]   nbytes,
  input  logic         last,
  input  logic         seg,
  input  logic         aad_ready,
  input  logic         pld_ready,
  output logic         ready,
  output logic         empty,
  output logic         out_valid,
  output logic         out_seg,
  output logic [127:0] out_data,
  output logic [15:0]  out_keep
);

  localparam int BW = BLK_BYTES * 8;
  localparam int WW = WORD_BYTES * 8;
  localparam int XW = BW + WW;

  logic [BW-1:0] acc_q;
  logic [4:0]    off_q;
  logic          flush_q;
  logic          flush_seg_q;
  logic [WW-1:0] wdat;
  logic [XW-1:0] ext;
  logic [4:0]    total;
  logic          pop;
  logic          free;

  assign pop   = out_valid
               && (out_seg ? pld_ready : aad_ready);
  assign free  = !out_valid || pop;
  assign ready = free && !flush_q;
  assign empty = !out_valid && !flush_q
               && (off_q == 5'd0);

  // Accumulator bytes at or above off_q are always zero, so the
  // new bytes can simply be OR-ed in at the current offset.
  always_comb begin
    wdat = '0;
    for (int b = 0; b < WORD_BYTES; b++)
      if (b < int'(nbytes))
        wdat[b*8 +: 8] = data[b*8 +: 8];
    ext = {{WW{1'b0}}, acc_q}
        | ({{BW{1'b0}}, wdat} << {off_q, 3'b000});
    total = off_q + {2'b00, nbytes};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      off_q       <= '0;
      flush_q     <= 1'b0;
      flush_seg_q <= 1'b0;
      out_valid   <= 1'b0;
      out_seg     <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
    end else if (clear) begin
      acc_q     <= '0;
      off_q     <= '0;
      flush_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (pop)
        out_valid <= 1'b0;
      // A last word that overflows a block leaves a tail that
      // must go out on a later cycle.
      if (flush_q && free) begin
        out_valid <= 1'b1;
        out_seg   <= flush_seg_q;
        out_data  <= acc_q;
        out_keep  <= cnt_mask(off_q);
        acc_q     <= '0;
        off_q     <= '0;
        flush_q   <= 1'b0;
      end else if (wr) begin
        if (total >= 5'(BLK_BYTES)) begin
          out_valid   <= 1'b1;
          out_seg     <= seg;
          out_data    <= ext[BW-1:0];
          out_keep    <= '1;
          acc_q       <= {{(BW-WW){1'b0}}, ext[XW-1:BW]};
          off_q       <= total - 5'(BLK_BYTES);
          flush_q     <= last
                      && (total != 5'(BLK_BYTES));
          flush_seg_q <= seg;
        end else if (last) begin
          out_valid <= (total != 5'd0);
          out_seg   <= seg;
          out_data  <= ext[BW-1:0];
          out_keep  <= cnt_mask(total);
          acc_q     <= '0;
          off_q     <= '0;
        end else begin
          acc_q <= ext[BW-1:0];
          off_q <= total;
        end
      end
    end
  end

endmodule

// File: rtl/chacha_aead_formatter.sv
// chacha_aead_formatter: splits an AAD+payload word stream into 16-byte
// blocks and a final {pld_bytes, aad_bytes} length block.
// Ports: clk/rst, start/busy/done/err, in_* word stream, aad_* and
// pld_* block outputs (one shared register), len_* length block.
// Macro CHACHA_FMT_PROTO_CHECK_EN: enables in_keep checking with err.
module chacha_aead_formatter
  import chacha_fmt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [3:0]   in_keep,
  input  logic         in_last,
  output logic         aad_valid,
  output logic [127:0] aad_data,
  output logic [15:0]  aad_keep,
  input  logic         aad_ready,
  output logic         pld_valid,
  output logic [127:0] pld_data,
  output logic [15:0]  pld_keep,
  input  logic         pld_ready,
  output logic         len_valid,
  output logic [127:0] len_block,
  input  logic         len_ready
);

  state_t           state_q;
  logic [CNT_W-1:0] aad_cnt_q;
  logic [CNT_W-1:0] pld_cnt_q;
  logic             drain_q;
  logic             err_q;
  logic [2:0]       nbytes;
  logic             bad;
  logic             seg_open;
  logic             acc_word;
  logic             wr;
  logic             pk_ready;
  logic             pk_empty;
  logic             reg_valid;
  logic             reg_seg;
  logic [127:0]     reg_data;
  logic [15:0]      reg_keep;

`ifdef CHACHA_FMT_PROTO_CHECK_EN
  // Keep must be LSB-contiguous and only a last word may be partial.
  assign bad = !(in_keep == 4'h0 || in_keep == 4'h1
              || in_keep == 4'h3 || in_keep == 4'h7
              || in_keep == 4'hF)
            || (in_keep != 4'hF && !in_last);
`else
  assign bad = 1'b0;
`endif

  // drain_q: payload last seen, waiting for the block register to
  // empty before presenting the length block.
  assign seg_open = (state_q == ST_AAD)
                 || (state_q == ST_PLD && !drain_q);
  assign in_ready = seg_open && pk_ready && !start;
  assign acc_word = in_valid && in_ready;
  assign wr       = acc_word && !bad;
  assign nbytes   = keep_cnt(in_keep);

  chacha_fmt_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .wr        (wr),
    .data      (in_data),
    .nbytes    (nbytes),
    .last      (in_last),
    .seg       (state_q == ST_PLD),
    .aad_ready (aad_ready),
    .pld_ready (pld_ready),
    .ready     (pk_ready),
    .empty     (pk_empty),
    .out_valid (reg_valid),
    .out_seg   (reg_seg),
    .out_data  (reg_data),
    .out_keep  (reg_keep)
  );

  assign aad_valid = reg_valid && !reg_seg;
  assign pld_valid = reg_valid && reg_seg;
  assign aad_data  = reg_data;
  assign pld_data  = reg_data;
  assign aad_keep  = reg_keep;
  assign pld_keep  = reg_keep;
  assign len_valid = (state_q == ST_LEN);
  assign len_block = {pld_cnt_q, aad_cnt_q};
  assign done      = len_valid && len_ready;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aad_cnt_q <= '0;
      pld_cnt_q <= '0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= acc_word && bad;
      if (start) begin
        state_q   <= ST_AAD;
        aad_cnt_q <= '0;
        pld_cnt_q <= '0;
        drain_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_AAD: if (wr) begin
            aad_cnt_q <= aad_cnt_q + CNT_W'(nbytes);
            if (in_last)
              state_q <= ST_PLD;
          end
          ST_PLD: if (drain_q) begin
            if (pk_empty) begin
              state_q <= ST_LEN;
              drain_q <= 1'b0;
            end
          end else if (wr) begin
            pld_cnt_q <= pld_cnt_q + CNT_W'(nbytes);
            if (in_last)
              drain_q <= 1'b1;
          end
          ST_LEN: if (len_ready)
            state_q <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_aead_formatter.sv
// tb_chacha_aead_formatter: scoreboard bench with a byte-queue model.
// Expected blocks are derived from per-segment byte lists.
module tb_chacha_aead_formatter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_keep = '0;
  logic         in_last = 1'b0;
  logic         aad_valid;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         aad_ready = 1'b0;
  logic         pld_valid;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         pld_ready = 1'b0;
  logic         len_valid;
  logic [127:0] len_block;
  logic         len_ready = 1'b0;

  always #5 clk = ~clk;

  chacha_aead_formatter dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last),
    .aad_valid(aad_valid), .aad_data(aad_data),
    .aad_keep(aad_keep), .aad_ready(aad_ready),
    .pld_valid(pld_valid), .pld_data(pld_data),
    .pld_keep(pld_keep), .pld_ready(pld_ready),
    .len_valid(len_valid), .len_block(len_block),
    .len_ready(len_ready)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
  } blk_t;

  blk_t         exp_aad[$];
  blk_t         exp_pld[$];
  logic [127:0] exp_len[$];
  logic [7:0]   m_aad[$];
  logic [7:0]   m_pld[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int exp_done = 0;
  int err_seen = 0;
  int exp_err = 0;
  bit rdy_rand = 1'b0;
  bit start_seen = 1'b0;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h",
               name, got, want);
    end
  endtask

  // Reference: a segment is its byte list cut into 16-byte blocks.
  task automatic blockify(input bit p);
    logic [7:0] q[$];
    blk_t b;
    if (p) q = m_pld; else q = m_aad;
    for (int i = 0; i < q.size(); i += 16) begin
      b = '0;
      for (int k = 0; k < 16 && i + k < q.size(); k++) begin
        b.data |= 128'(q[i+k]) << (8 * k);
        b.keep |= 16'(1) << k;
      end
      if (p) exp_pld.push_back(b);
      else exp_aad.push_back(b);
    end
  endtask

  task automatic model_push(input bit with_len);
    blockify(1'b0);
    blockify(1'b1);
    if (with_len) begin
      exp_len.push_back({64'(m_pld.size()),
                         64'(m_aad.size())});
      exp_done++;
    end
  endtask

  task automatic fill_rand(input int na, input int np);
    m_aad.delete();
    m_pld.delete();
    for (int i = 0; i < na; i++) m_aad.push_back(8'($urandom));
    for (int i = 0; i < np; i++) m_pld.push_back(8'($urandom));
  endtask

  function automatic logic [31:0] pword(input int i);
    return {m_pld[4*i+3], m_pld[4*i+2],
            m_pld[4*i+1], m_pld[4*i]};
  endfunction

  task automatic send_word(input logic [31:0] d,
                           input logic [3:0] k,
                           input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got=0 want=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
  endtask

  task automatic send_seg(input bit p);
    logic [7:0]  q[$];
    logic [31:0] d;
    logic [3:0]  k;
    if (p) q = m_pld; else q = m_aad;
    if (q.size() == 0) send_word('0, 4'h0, 1'b1);
    for (int i = 0; i < q.size(); i += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4 && i + j < q.size(); j++) begin
        d |= 32'(q[i+j]) << (8 * j);
        k |= 4'(1) << j;
      end
      send_word(d, k, (i + 4 >= q.size()));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_after_msg", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg();
    model_push(1'b1);
    pulse_start();
    send_seg(1'b0);
    send_seg(1'b1);
    wait_idle();
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) begin
      aad_ready = ($urandom % 4) != 0;
      pld_ready = ($urandom % 4) != 0;
      len_ready = ($urandom % 3) != 0;
    end
  end

  always @(posedge clk) start_seen <= start;

  blk_t         e;
  logic [127:0] el;
  logic         av_q = 1'b0, ar_q = 1'b0;
  logic         pv_q = 1'b0, pr_q = 1'b0;
  blk_t         ab_q, pb_q;

  always @(negedge clk) begin
    if (rst) begin
      av_q = 1'b0;
      pv_q = 1'b0;
    end else begin
      check("valid_onehot",
            (int'(aad_valid) + int'(pld_valid)
             + int'(len_valid)) <= 1, 1);
      if (aad_valid && aad_ready) begin
        if (exp_aad.size() == 0) begin
          total++;
          bad++;
          $display("FAIL aad_unexpected: got=%h want=none",
                   aad_data);
        end else begin
          e = exp_aad.pop_front();
          check("aad_data", aad_data, e.data);
          check("aad_keep", aad_keep, e.keep);
        end
      end
      if (pld_valid && pld_ready) begin
        if (exp_pld.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pld_unexpected: got=%h want=none",
                   pld_data);
        end else begin
          e = exp_pld.pop_front();
          check("pld_data", pld_data, e.data);
          check("pld_keep", pld_keep, e.keep);
        end
      end
      if (len_valid && len_ready) begin
        if (exp_len.size() == 0) begin
          total++;
          bad++;
          $display("FAIL len_unexpected: got=%h want=none",
                   len_block);
        end else begin
          el = exp_len.pop_front();
          check("len_block", len_block, el);
        end
      end
      if (done) done_seen++;
      if (err) err_seen++;
      if (av_q && !ar_q && !start_seen) begin
        check("aad_hold_valid", aad_valid, 1);
        check("aad_hold_data", aad_data, ab_q.data);
        check("aad_hold_keep", aad_keep, ab_q.keep);
      end
      if (pv_q && !pr_q && !start_seen) begin
        check("pld_hold_valid", pld_valid, 1);
        check("pld_hold_data", pld_data, pb_q.data);
        check("pld_hold_keep", pld_keep, pb_q.keep);
      end
      av_q = aad_valid;
      ar_q = aad_ready;
      ab_q = {aad_data, aad_keep};
      pv_q = pld_valid;
      pr_q = pld_ready;
      pb_q = {pld_data, pld_keep};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  logic [127:0] bp_data;
  int           nw;

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_aad_valid", aad_valid, 0);
    check("rst_pld_valid", pld_valid, 0);
    check("rst_len_valid", len_valid, 0);
    check("rst_len_block", len_block, 0);
    check("rst_data", aad_data | pld_data, 0);
    check("rst_done_err", {done, err}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    aad_ready = 1'b1;
    pld_ready = 1'b1;
    len_ready = 1'b1;
    @(posedge clk);
    #1;

    // basic flow: 12 AAD bytes 00..0B, 16 payload bytes
    m_aad.delete();
    m_pld.delete();
    for (int i = 0; i < 12; i++) m_aad.push_back(8'(i));
    for (int i = 0; i < 16; i++) m_pld.push_back(8'(8'h40 + i));
    run_msg();

    // empty AAD, 17-byte payload
    fill_rand(0, 17);
    run_msg();

    // backpressure: hold pld_ready low with a block pending
    rdy_rand = 1'b0;
    aad_ready = 1'b1;
    pld_ready = 1'b0;
    len_ready = 1'b1;
    fill_rand(0, 32);
    bp_data = '0;
    for (int k = 0; k < 16; k++)
      bp_data |= 128'(m_pld[k]) << (8 * k);
    model_push(1'b1);
    pulse_start();
    send_seg(1'b0);
    for (int i = 0; i < 4; i++) send_word(pword(i), 4'hF, 1'b0);
    in_valid = 1'b1;
    in_data  = pword(4);
    in_keep  = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_pld_valid", pld_valid, 1);
      check("bp_pld_data", pld_data, bp_data);
      check("bp_pld_keep", pld_keep, 16'hFFFF);
    end
    @(posedge clk);
    #1;
    pld_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_word(pword(i), 4'hF, i == 7);
    wait_idle();

    rdy_rand = 1'b1;
`ifdef CHACHA_FMT_PROTO_CHECK_EN
    // illegal keeps are dropped and flagged
    fill_rand(8, 5);
    model_push(1'b1);
    pulse_start();
    send_word(32'hDEADBEEF, 4'b0101, 1'b0);
    exp_err++;
    send_seg(1'b0);
    send_word(32'h12345678, 4'h7, 1'b0);
    exp_err++;
    send_seg(1'b1);
    wait_idle();
`else
    // unchecked keeps: popcount of low bytes, unaligned packing
    m_aad.delete();
    m_pld.delete();
    m_aad.push_back(8'h11);
    m_aad.push_back(8'h22);
    for (int i = 1; i <= 4; i++) m_aad.push_back(8'(i));
    for (int i = 0; i < 14; i++) m_pld.push_back(8'(8'h20 + i));
    for (int i = 0; i < 4; i++) m_pld.push_back(8'(8'h60 + i));
    model_push(1'b1);
    pulse_start();
    send_word(32'h44332211, 4'b0101, 1'b0);
    send_word(32'h04030201, 4'hF, 1'b1);
    for (int i = 0; i < 7; i++)
      send_word({16'hA5A5, m_pld[2*i+1], m_pld[2*i]},
                4'b0011, 1'b0);
    send_word(32'h63626160, 4'hF, 1'b1);
    wait_idle();
`endif

    // abort by start while a payload block is pending
    rdy_rand = 1'b0;
    aad_ready = 1'b1;
    pld_ready = 1'b0;
    len_ready = 1'b1;
    fill_rand(0, 16);
    pulse_start();
    send_word('0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) send_word(pword(i), 4'hF, 1'b0);
    @(negedge clk);
    check("abort_pre_valid", pld_valid, 1);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_valid_drop", pld_valid, 0);
    check("abort_busy", busy, 1);
    check("abort_len_clear", len_block, 0);
    @(posedge clk);
    #1;
    rdy_rand = 1'b1;
    fill_rand(5, 9);
    run_msg();

    // reset while the length block waits in LEN
    rdy_rand = 1'b0;
    aad_ready = 1'b1;
    pld_ready = 1'b1;
    len_ready = 1'b0;
    fill_rand(10, 7);
    model_push(1'b0);
    pulse_start();
    send_seg(1'b0);
    send_seg(1'b1);
    nw = 0;
    @(negedge clk);
    while (!len_valid && nw < 100) begin
      @(negedge clk);
      nw++;
    end
    check("pre_rst_len_valid", len_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_len_valid", len_valid, 0);
    check("mid_rst_len_block", len_block, 0);
    check("mid_rst_valids", {aad_valid, pld_valid}, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_done_err", {done, err}, 0);
    check("mid_rst_data", aad_data | pld_data, 0);
    len_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_done", done, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rdy_rand = 1'b1;

    for (int m = 0; m < 25; m++) begin
      fill_rand($urandom_range(0, 40), $urandom_range(0, 40));
      run_msg();
    end

    repeat (4) @(posedge clk);
    check("aad_left", exp_aad.size(), 0);
    check("pld_left", exp_pld.size(), 0);
    check("len_left", exp_len.size(), 0);
    check("done_count", done_seen, exp_done);
    check("err_count", err_seen, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chacha_aead_formatter.md
CHACHA_AEAD_FORMATTER -- requirements
Module: chacha_aead_formatter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; the ports are listed first below.
  - clk  in  1  sole clock, rising edge
  - rst  in  1  asynchronous reset, active-high
REQ-002 SHALL provide the message-control ports:
  - start  in  1  pulse; begin a new message
  - busy  out  1  high while not IDLE
  - done  out  1  one-cycle pulse when the length block is accepted
  - err  out  1  one-cycle pulse on a protocol violation
REQ-003 SHALL provide the 32-bit input stream ports:
  - in_valid  in  1
  - in_ready  out  1
  - in_data  in  32  byte i at bits [8i+7:8i]
  - in_keep  in  4  byte enables, LSB-contiguous
  - in_last  in  1  last word of the current segment
REQ-004 SHALL provide the AAD block outputs:
  - aad_valid  out  1
  - aad_data  out  128
  - aad_keep  out  16
  - aad_ready  in  1
REQ-005 SHALL provide the payload block outputs:
  - pld_valid  out  1
  - pld_data  out  128
  - pld_keep  out  16
  - pld_ready  in  1
REQ-006 SHALL provide the length block outputs:
  - len_valid  out  1
  - len_block  out  128
  - len_ready  in  1

Function
REQ-007 SHALL implement states IDLE, AAD, PLD, LEN.
  - start (any state) -> AAD.
  - Accepted word with in_last in AAD -> PLD.
  - Accepted word with in_last in PLD -> LEN once the output register is empty.
  - len handshake -> IDLE, with done pulsed in the same cycle.
REQ-008 SHALL pack input bytes in arrival order into a 128-bit accumulator; block byte k sits at bits [8k+7:8k].
REQ-009 SHALL emit a block when 16 bytes are accumulated, or when in_last is accepted with 1-15 bytes pending.
  - keep = low N bits set (N = pending bytes).
  - Unused data bytes = 0.
REQ-010 SHALL emit no block for a segment with zero bytes; a last word with in_keep=0 is legal.
REQ-011 SHALL hold one registered output block shared by the AAD and payload outputs.
  - aad_valid = reg valid AND segment=AAD; pld_valid = reg valid AND segment=PLD.
  - The block appears the cycle after the completing word is accepted.
REQ-012 SHALL drive in_ready = (state is AAD or PLD) AND (reg empty OR selected ready high).
  - Full one-word-per-cycle throughput when the output drains.
REQ-013 SHALL hold output data, keep and valid stable while valid is high and ready is low.
REQ-014 SHALL count AAD bytes and payload bytes in 64-bit counters; the counters wrap modulo 2^64.
REQ-015 SHALL drive len_block = {pld_bytes[63:0], aad_bytes[63:0]}, with the AAD count in bits [63:0], and hold len_valid high in LEN until len_ready.
REQ-016 SHALL never assert more than one of aad_valid, pld_valid, len_valid in the same cycle.
REQ-017 SHALL, on start in a non-IDLE state, drop any pending block (valids low the next cycle), clear the accumulator and counters, and enter AAD.
REQ-018 SHALL ignore in_valid in IDLE and LEN; in_ready is 0 in those states.

Reset
REQ-019 SHALL, while rst is high, force state IDLE, clear the counters and accumulator, and drive all outputs to 0: valids, busy, done, err, in_ready, data, keep, len_block.
REQ-020 SHALL, on rst asserted mid-message, discard all in-flight data; no output handshake completes after the reset edge.

Configuration
REQ-021 SHALL honour macro CHACHA_FMT_PROTO_CHECK_EN.
  - Defined: non-contiguous in_keep, or in_keep != 4'hF without in_last, pulses err and drops that word; state and counters are unchanged.
  - Undefined: err tied 0; in_keep is treated as the count of its set bits, with no checking.

Structure
REQ-022 SHALL place the state enum, BLK_BYTES=16, WORD_BYTES=4, CNT_W=64 and a keep-to-byte-count function in package chacha_fmt_pkg.
REQ-023 SHALL isolate the accumulator, byte-offset logic and output register in sub-module chacha_fmt_pack; the FSM and counters remain in the top module.

Verification
REQ-024 SHALL cover the basic AAD + payload flow.
  - Stimulus: start; AAD words 0x03020100, 0x07060504, 0x0B0A0908(last); payload 4 full words, the 4th last.
  - Response: aad_data[95:0]=0x0B0A09080706050403020100, aad_keep=16'h0FFF; pld_keep=16'hFFFF; len_block=128'h0000000000000010_000000000000000C; done pulses.
REQ-025 SHALL cover an empty AAD segment.
  - Stimulus: word with keep=0, last=1; then a 17-byte payload.
  - Response: no aad_valid; pld blocks with keep FFFF then 0001; len_block=128'h0000000000000011_0000000000000000.
REQ-026 SHALL cover backpressure.
  - Stimulus: pld_ready low for 5 cycles while a block is pending.
  - Response: in_ready low for those cycles; pld_data/keep stable; no byte loss or duplication.
REQ-027 SHALL cover protocol-violation handling with the macro defined.
  - Stimulus: in_keep=4'b0101.
  - Response: err pulse; word dropped; final len_block excludes those bytes.
REQ-028 SHALL cover abort by start.
  - Stimulus: start pulsed mid-payload while pld_valid is high.
  - Response: pld_valid low the next cycle; the new message's len_block reflects only the new bytes.
REQ-029 SHALL cover reset mid-operation.
  - Stimulus: rst pulsed during LEN.
  - Response: all outputs 0 immediately; busy=0; no done pulse.
